// File: rtl/bw_pulse_capture.sv
`default_nettype none
// ============================================================================
//  Module   : bw_pulse_capture
//  Brief    : Four-channel input capture; measures period and high time of
//             synchronized inputs, with bus registers and per-channel IRQ.
//  Revision : 1.0
// ============================================================================
module bw_pulse_capture #(
    parameter logic [31:0] LIMIT_RST = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [5:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        in0,
    input  logic        in1,
    input  logic        in2,
    input  logic        in3,
    output logic        irq_o
);
    localparam int         c_num_ch   = 4;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_high  = 2'd1;
    localparam logic [1:0] c_st_low   = 2'd2;

    logic        w_cs;
    logic        w_wr;
    logic        rdy_q;
    logic [31:0] dat_o_q, dat_o_d;
    logic [31:0] w_rdata;
    logic [3:0]  w_in;
    logic [3:0]  w_irq;
    logic [31:0] w_period [c_num_ch];
    logic [31:0] w_high   [c_num_ch];
    logic [31:0] w_limit  [c_num_ch];
    logic [31:0] w_stat   [c_num_ch];

    assign w_cs  = cyc_i & stb_i & cs_i;
    assign w_wr  = w_cs & we_i;
    assign w_in  = {in3, in2, in1, in0};
    assign ack_o = w_cs & (we_i | rdy_q);
    assign dat_o = dat_o_q;
    assign irq_o = |w_irq;

    genvar gi;
    generate
        for (gi = 0; gi < c_num_ch; gi++) begin : g_ch
            logic [1:0]  state_q, state_d;
            logic        sync1_q, sync2_q, prev_q;
            logic [31:0] cnt_q, cnt_d, hshadow_q, hshadow_d;
            logic [31:0] period_q, period_d, high_q, high_d, limit_q, limit_d;
            logic        en_q, en_d, pol_q, pol_d, ie_q, ie_d;
            logic        valid_q, valid_d, ovr_q, ovr_d, tmo_q, tmo_d;
            logic        w_sel_ch, w_wr_ctrl, w_wr_limit, w_clr;
            logic        w_start, w_stop, w_timeout, w_arm, w_end, w_capture;
            logic [31:0] w_cnt_inc;

            assign w_sel_ch   = (adr_i[5:4] == 2'(gi));
            assign w_wr_ctrl  = w_wr & w_sel_ch & (adr_i[3:2] == 2'd3);
            assign w_wr_limit = w_wr & w_sel_ch & (adr_i[3:2] == 2'd2);
            assign w_clr      = w_wr_ctrl & sel_i[0] & dat_i[2];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q   <= c_st_idle;
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    prev_q    <= 1'b0;
                    cnt_q     <= '0;
                    hshadow_q <= '0;
                    period_q  <= '0;
                    high_q    <= '0;
                    limit_q   <= LIMIT_RST;
                    en_q      <= 1'b0;
                    pol_q     <= 1'b0;
                    ie_q      <= 1'b0;
                    valid_q   <= 1'b0;
                    ovr_q     <= 1'b0;
                    tmo_q     <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    sync1_q   <= w_in[gi];
                    sync2_q   <= sync1_q;
                    prev_q    <= sync2_q;
                    cnt_q     <= cnt_d;
                    hshadow_q <= hshadow_d;
                    period_q  <= period_d;
                    high_q    <= high_d;
                    limit_q   <= limit_d;
                    en_q      <= en_d;
                    pol_q     <= pol_d;
                    ie_q      <= ie_d;
                    valid_q   <= valid_d;
                    ovr_q     <= ovr_d;
                    tmo_q     <= tmo_d;
                end
            end

            // Decoded per-cycle events; timeout pre-empts any edge in the same cycle
            always_comb begin
                w_start   = pol_q ? (prev_q & ~sync2_q) : (~prev_q & sync2_q);
                w_stop    = pol_q ? (~prev_q & sync2_q) : (prev_q & ~sync2_q);
                w_timeout = en_q && ((state_q == c_st_high) || (state_q == c_st_low)) &&
                            (limit_q != '0) && (cnt_q == limit_q);
                w_arm     = en_q && (state_q == c_st_idle) && w_start;
                w_end     = en_q && (state_q == c_st_high) && w_stop && !w_timeout;
                w_capture = en_q && (state_q == c_st_low) && w_start && !w_timeout && !w_clr;
            end

            always_comb begin
                state_d = state_q;
                if (w_clr || !en_q || w_timeout) begin
                    state_d = c_st_idle;
                end else begin
                    case (state_q)
                        c_st_idle: if (w_start) state_d = c_st_high;
                        c_st_high: if (w_stop)  state_d = c_st_low;
                        c_st_low:  if (w_start) state_d = c_st_high;
                        default:   state_d = c_st_idle;
                    endcase
                end
            end

            always_comb begin
                w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
                cnt_d     = w_cnt_inc;
                hshadow_d = hshadow_q;
                period_d  = period_q;
                high_d    = high_q;
                limit_d   = limit_q;
                en_d      = en_q;
                pol_d     = pol_q;
                ie_d      = ie_q;
                valid_d   = valid_q;
                ovr_d     = ovr_q;
                tmo_d     = tmo_q;

                if (!en_q || w_timeout)                 cnt_d = '0;
                else if (w_arm || w_capture)            cnt_d = 32'd1;
                else if (state_q == c_st_idle)          cnt_d = '0;

                if (w_end) hshadow_d = cnt_q;
                if (w_capture) begin
                    period_d = cnt_q;
                    high_d   = hshadow_q;
                end

                if (w_wr_limit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel_i[b]) limit_d[8*b +: 8] = dat_i[8*b +: 8];
                    end
                end
                if (w_wr_ctrl && sel_i[0]) begin
                    en_d  = dat_i[0];
                    pol_d = dat_i[1];
                    ie_d  = dat_i[3];
                end
                if (w_wr_ctrl && sel_i[1]) begin
                    if (dat_i[8])  valid_d = 1'b0;
                    if (dat_i[9])  ovr_d   = 1'b0;
                    if (dat_i[10]) tmo_d   = 1'b0;
                end
                // Hardware events override a same-cycle write-1-to-clear
                if (w_capture) begin
                    valid_d = 1'b1;
                    ovr_d   = valid_q;
                end
                if (w_timeout) tmo_d = 1'b1;

                if (w_clr) begin
                    cnt_d     = '0;
                    hshadow_d = '0;
                    period_d  = '0;
                    high_d    = '0;
                    valid_d   = 1'b0;
                    ovr_d     = 1'b0;
                    tmo_d     = 1'b0;
                end
            end

            assign w_period[gi] = period_q;
            assign w_high[gi]   = high_q;
            assign w_limit[gi]  = limit_q;
            assign w_stat[gi]   = {21'd0, tmo_q, ovr_q, valid_q, 4'd0, ie_q, 1'b0, pol_q, en_q};
            assign w_irq[gi]    = valid_q & ie_q;
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (adr_i[3:2])
            2'd0:    w_rdata = w_period[adr_i[5:4]];
            2'd1:    w_rdata = w_high[adr_i[5:4]];
            2'd2:    w_rdata = w_limit[adr_i[5:4]];
            default: w_rdata = w_stat[adr_i[5:4]];
        endcase
        dat_o_d = w_cs ? w_rdata : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            rdy_q   <= w_cs;
            dat_o_q <= dat_o_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bw_pulse_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bw_pulse_capture
//  Brief    : Directed self-checking bench for bw_pulse_capture.
//  Revision : 1.0
// ============================================================================
module tb_bw_pulse_capture;
    localparam logic [31:0] LIMIT_RST = 32'd0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cs_i, cyc_i, stb_i, we_i;
    logic        ack_o;
    logic [3:0]  sel_i;
    logic [5:0]  adr_i;
    logic [31:0] dat_i, dat_o;
    logic [3:0]  in_v;
    logic        irq_o;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    bw_pulse_capture #(.LIMIT_RST(LIMIT_RST)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_o(ack_o), .sel_i(sel_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
        .dat_o(dat_o), .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        total++;
        assert (obs === e) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_idle();
        cyc_i = 0; stb_i = 0; cs_i = 0; we_i = 0;
        adr_i = '0; dat_i = '0; sel_i = '0;
    endtask

    task automatic hold(input logic [3:0] m, input logic v, input int n);
        if (v) in_v = in_v | m;
        else   in_v = in_v & ~m;
        repeat (n) step();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc_i = 1; stb_i = 1; cs_i = 1; we_i = 1; adr_i = a; dat_i = d; sel_i = s;
        #1 chk("wr_ack", 32'(ack_o), 32'd1);
        step();
        bus_idle();
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e, input string tag);
        int n;
        step();
        exp_q.push_back(e);
        tag_q.push_back(tag);
        cyc_i = 1; stb_i = 1; cs_i = 1; we_i = 0; adr_i = a; sel_i = 4'hF;
        #1 chk({tag, "_ack_early"}, 32'(ack_o), 32'd0);
        n = 0;
        do begin step(); n++; end while (!ack_o && n < 4);
        chk({tag, "_ack_lat"}, 32'(n), 32'd1);
        chk(tag_q.pop_front(), dat_o, exp_q.pop_front());
        bus_idle();
    endtask

    initial begin
        rst_i = 1'b1;
        in_v  = '0;
        bus_idle();
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        repeat (2) step();
        rst_i = 1'b0;
        step();

        rd(6'h08, LIMIT_RST, "ch0_limit_rst");
        rd(6'h0C, 32'h0, "ch0_stat_rst");

        // ch0 pol=0, ch1 pol=1 on a 10-high / 30-low wave
        wr(6'h0C, 32'h1, 4'b0001);
        wr(6'h1C, 32'h3, 4'b0001);
        hold(4'b0011, 1'b1, 10);
        hold(4'b0011, 1'b0, 30);
        hold(4'b0011, 1'b1, 10);
        hold(4'b0011, 1'b0, 5);
        chk("irq_no_ie", 32'(irq_o), 32'd0);
        rd(6'h00, 32'd40, "ch0_period");
        rd(6'h04, 32'd10, "ch0_high");
        rd(6'h0C, 32'h101, "ch0_stat");
        wr(6'h0C, 32'h9, 4'b0001);
        chk("irq_ch0_ie", 32'(irq_o), 32'd1);
        rd(6'h10, 32'd40, "ch1_period");
        rd(6'h14, 32'd30, "ch1_high");
        rd(6'h1C, 32'h103, "ch1_stat");
        wr(6'h1C, 32'hB, 4'b0001);
        wr(6'h0C, 32'h100, 4'b0010);
        chk("irq_ch1_only", 32'(irq_o), 32'd1);
        wr(6'h1C, 32'h100, 4'b0010);
        chk("irq_cleared", 32'(irq_o), 32'd0);
        rd(6'h1C, 32'h00B, "ch1_stat_w1c");

        // byte-lane LIMIT write
        wr(6'h38, 32'h12345678, 4'b0101);
        rd(6'h38, 32'h00340078, "ch3_limit_lanes");
        wr(6'h38, 32'h0, 4'b1111);

        // ch2 timeout at LIMIT=100 with a continuous read of CTRL/STAT
        wr(6'h28, 32'd100, 4'b1111);
        wr(6'h2C, 32'h1, 4'b0001);
        cyc_i = 1; stb_i = 1; cs_i = 1; we_i = 0; adr_i = 6'h2C; sel_i = 4'hF;
        step();
        in_v[2] = 1'b1;
        repeat (5) step();
        in_v[2] = 1'b0;
        repeat (98) step();
        chk("ch2_tmo_early", 32'(dat_o[10]), 32'd0);
        step();
        chk("ch2_tmo_exact", 32'(dat_o[10]), 32'd1);
        bus_idle();
        rd(6'h20, 32'd0, "ch2_period_after_tmo");
        hold(4'b0100, 1'b1, 8);
        hold(4'b0100, 1'b0, 12);
        hold(4'b0100, 1'b1, 5);
        rd(6'h20, 32'd20, "ch2_period_fresh");
        rd(6'h24, 32'd8, "ch2_high_fresh");
        rd(6'h2C, 32'h501, "ch2_stat_fresh");

        // ch3 overrun, then W1C of valid coinciding with a capture
        wr(6'h3C, 32'h1, 4'b0001);
        hold(4'b1000, 1'b1, 6);
        hold(4'b1000, 1'b0, 14);
        hold(4'b1000, 1'b1, 5);
        hold(4'b1000, 1'b0, 10);
        hold(4'b1000, 1'b1, 5);
        rd(6'h30, 32'd15, "ch3_period_latest");
        rd(6'h34, 32'd5, "ch3_high_latest");
        rd(6'h3C, 32'h301, "ch3_stat_ovr");
        hold(4'b1000, 1'b1, 4);
        hold(4'b1000, 1'b0, 8);
        in_v[3] = 1'b1;
        step();
        step();
        wr(6'h3C, 32'h100, 4'b0010);
        repeat (3) step();
        rd(6'h3C, 32'h301, "ch3_capture_beats_w1c");
        wr(6'h3C, 32'h300, 4'b0010);
        rd(6'h3C, 32'h001, "ch3_stat_w1c");

        // clr mid-HIGH on ch0
        hold(4'b0001, 1'b1, 5);
        wr(6'h0C, 32'h5, 4'b0001);
        rd(6'h00, 32'd0, "ch0_period_clr");
        rd(6'h04, 32'd0, "ch0_high_clr");
        rd(6'h0C, 32'h001, "ch0_stat_clr");
        chk("irq_after_clr", 32'(irq_o), 32'd0);
        hold(4'b0001, 1'b0, 5);
        hold(4'b0001, 1'b1, 5);
        rd(6'h0C, 32'h001, "ch0_no_capture_after_clr");
        rd(6'h00, 32'd0, "ch0_period_after_arm");
        step();
        chk("dat_idle", dat_o, 32'd0);

        // asynchronous reset in the middle of a read
        wr(6'h3C, 32'h9, 4'b0001);
        hold(4'b1000, 1'b0, 5);
        hold(4'b1000, 1'b1, 5);
        chk("irq_ch3", 32'(irq_o), 32'd1);
        step();
        cyc_i = 1; stb_i = 1; cs_i = 1; we_i = 0; adr_i = 6'h30; sel_i = 4'hF;
        step();
        chk("pre_rst_ack", 32'(ack_o), 32'd1);
        #3 rst_i = 1'b1;
        #1;
        chk("async_rst_ack", 32'(ack_o), 32'd0);
        chk("async_rst_dat", dat_o, 32'd0);
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus_idle();
        rd(6'h28, LIMIT_RST, "ch2_limit_after_rst");
        for (int c = 0; c < 4; c++) begin
            rd({c[1:0], 4'h0}, 32'd0, "period_after_rst");
            rd({c[1:0], 4'hC}, 32'd0, "stat_after_rst");
        end
        wr(6'h0C, 32'h1, 4'b0001);
        hold(4'b0001, 1'b0, 5);
        hold(4'b0001, 1'b1, 5);
        rd(6'h0C, 32'h001, "ch0_first_edge_arms");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
